// File: rtl/mem_access_unit_if.sv
// Request-side and memory-bus signals of mem_access_unit bundled into one interface.
// slave is the unit's view; master is the view of the block that drives requests and models memory.
interface mem_access_unit_if;
    localparam int unsigned W = 32;

    logic         start;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         mem_ready;
    logic [W-1:0] mem_rdata;

    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_rd;
    logic         mem_wr;
    logic [W-1:0] rdata;
    logic         busy;
    logic         done;
    logic         error;

    modport slave (
        input  start, we, addr, wdata, mem_ready, mem_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr, rdata, busy, done, error
    );

    modport master (
        output start, we, addr, wdata, mem_ready, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, rdata, busy, done, error
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-word load/store unit: IDLE -> ACCESS -> DONE, with an alignment check on the request.
// Defining MEM_ACCESS_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES ACCESS cycles without mem_ready.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);
    localparam int unsigned W = 32;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q;
    logic         we_q;
    logic [W-1:0] mem_addr_q;
    logic [W-1:0] mem_wdata_q;
    logic         mem_rd_q;
    logic         mem_wr_q;
    logic [W-1:0] rdata_q;
    logic         busy_q;
    logic         done_q;
    logic         error_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
`endif

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.addr[1:0] == 2'b00) begin
                            mem_addr_q  <= bus.addr;
                            mem_wdata_q <= bus.wdata;
                            we_q        <= bus.we;
                            mem_rd_q    <= ~bus.we;
                            mem_wr_q    <= bus.we;
                            error_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            cnt_q       <= 8'd0;
`endif
                            state_q     <= ACCESS;
                        end else begin
                            // Misaligned: never touch the bus, report straight away.
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        error_q  <= 1'b0;
                        done_q   <= 1'b1;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= DONE;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    // Ready takes priority over the abort in the final allowed cycle.
                    else if (cnt_q == LAST_CNT) begin
                        error_q  <= 1'b1;
                        done_q   <= 1'b1;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of ACCESS cycles allowed without mem_ready before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load; latched with start.
REQ-006 addr  input  32  effective address from the offset filter stage; latched with start.
REQ-007 wdata  input  32  store data; latched with start.
REQ-008 mem_ready  input  1  bus completion; valid only while a strobe is high.
REQ-009 mem_rdata  input  32  bus read data; valid when mem_ready=1 during a load.
REQ-010 mem_addr  output  32  registered bus address.
REQ-011 mem_wdata  output  32  registered bus write data.
REQ-012 mem_rd  output  1  registered load strobe.
REQ-013 mem_wr  output  1  registered store strobe.
REQ-014 rdata  output  32  last successfully loaded word.
REQ-015 busy  output  1  high in ACCESS and DONE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 error  output  1  status of the completed request; valid while done=1.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; encoding is free.
REQ-019 IDLE, start=1, addr[1:0]=0: latch addr/wdata/we into mem_addr/mem_wdata/we_q, clear error, go to ACCESS.
REQ-020 IDLE, start=1, addr[1:0]!=0 (misaligned): no bus strobe, set error, go to DONE.
REQ-021 ACCESS: mem_rd = ~we_q, mem_wr = we_q; exactly one strobe high; strobes low in all other states.
REQ-022 ACCESS with mem_ready=1: loads latch mem_rdata into rdata, stores leave rdata unchanged; error=0; go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 start asserted while busy=1 is ignored; no queuing.
REQ-025 Latency: start sampled at edge N, mem_ready high in the first ACCESS cycle -> done high in cycle N+2 (minimum two cycles).
REQ-026 Misaligned latency: done high in the cycle after the start edge.
REQ-027 mem_addr, mem_wdata are held stable for the whole ACCESS state.
REQ-028 rdata is unchanged by misaligned, aborted or store requests.

Reset
REQ-029 rst_n low asynchronously forces IDLE; mem_rd, mem_wr, done, error, busy = 0; mem_addr, mem_wdata, rdata = 0; timeout counter = 0.
REQ-030 Reset during ACCESS drops strobes immediately, without a done pulse; first request after release behaves as from a clean state.

Configuration
REQ-031 Macro MEM_ACCESS_TIMEOUT_EN defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle; a cycle where count reaches TIMEOUT_CYCLES-1 with mem_ready=0 sets error and moves to DONE; strobes drop on that edge.
REQ-032 With the macro defined, mem_ready=1 in the final allowed cycle completes normally with error=0 (ready wins).
REQ-033 Macro undefined: no counter is instantiated; ACCESS waits indefinitely for mem_ready; error is raised only on misalignment.

Verification
REQ-034 Load: start, we=0, addr=0x00001000; mem_ready=1 with mem_rdata=0xDEADBEEF in the first ACCESS cycle -> mem_rd for one cycle, done two cycles after start, rdata=0xDEADBEEF, error=0.
REQ-035 Store with wait: start, we=1, addr=0x12312740, wdata=0xCAFEF00D; mem_ready held low 3 cycles -> mem_wr high 4 cycles, mem_addr/mem_wdata stable, done, error=0, rdata unchanged.
REQ-036 Misaligned: start, addr=0x12345677 -> no strobe ever, done next cycle with error=1.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): load, mem_ready never -> mem_rd high exactly 16 cycles, then done with error=1, rdata unchanged; repeat with mem_ready in cycle 16 -> error=0.
REQ-038 Busy/reset: second start during ACCESS ignored (single done pulse); rst_n low mid-ACCESS -> strobes 0 immediately, no done, next load completes normally.
